cv32e40x_pma_checker: RTL and testbench
=======================================

Name: cv32e40x_pma_checker

Overview:
- Multi-channel, pipelined PMA checker. One shared region table serves NUM_CH independent request channels, e.g. ch0 = instruction fetch and ch1 = load/store.
- Each channel has a single-entry registered response stage with valid/ready handshake.
- Reports the matched region index alongside err/bufferable/cacheable.
- Keeps a saturating error counter and a first-error capture register for debug/trace.

Parameters:
- A_EXT, A_NONE: atomic support. When A_NONE, the atomic attribute is forced to 0.
- PMA_NUM_REGIONS, 0: number of configured regions. 0 means deconfigured, and NO_PMA_R_DEFAULT applies.
- PMA_CFG, '{default:PMA_R_DEFAULT}: region table, pma_cfg_t[PMA_NUM_REGIONS-1:0].
- NUM_CH, 2: number of request channels, 1..4.
- ERR_CNT_W, 8: width of the error counter.
- REG_W, $clog2(PMA_NUM_REGIONS+2): region index width, derived, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid_i  in  NUM_CH  request valid, per channel.
- req_ready_o  out  NUM_CH  request ready, per channel.
- req_addr_i  in  NUM_CH x 32  byte address.
- req_debug_region_i  in  NUM_CH  address is in the DM region while in debug mode.
- req_pushpop_i  in  NUM_CH  access is part of a PUSH/POP sequence.
- req_instr_i  in  NUM_CH  access is an instruction fetch.
- req_atomic_i  in  NUM_CH  access is atomic.
- req_misaligned_i  in  NUM_CH  access is part of a misaligned access.
- req_modified_i  in  NUM_CH  access is part of a modified access.
- req_load_i  in  NUM_CH  access is a load.
- resp_valid_o  out  NUM_CH  response valid.
- resp_ready_i  in  NUM_CH  response ready.
- resp_err_o  out  NUM_CH  PMA error.
- resp_bufferable_o  out  NUM_CH  bufferable.
- resp_cacheable_o  out  NUM_CH  cacheable.
- resp_region_o  out  NUM_CH x REG_W  matched region index.
- err_valid_o  out  1  first-error record is held.
- err_ch_o  out  $clog2(NUM_CH) (min 1)  channel of the first error.
- err_addr_o  out  32  byte address of the first error.
- err_cnt_o  out  ERR_CNT_W  saturating count of errors.
- err_clear_i  in  1  clears the error record and counter.

Behaviour:
- Reset values:
  - resp_valid_o = 0; resp_err/bufferable/cacheable = 0; resp_region_o = 0.
  - err_valid_o = 0; err_ch_o = 0; err_addr_o = 0; err_cnt_o = 0.
- Handshake, per channel, independent of other channels:
  - req_ready_o = !resp_valid_o || resp_ready_i (combinational; no dependence on req_valid_i).
  - Accept occurs on req_valid_i && req_ready_o. Response fields are registered and resp_valid_o = 1 on the next cycle. Latency is 1 cycle.
  - Back-to-back accepts give full throughput.
  - While resp_valid_o && !resp_ready_i, all response outputs are held stable.
  - resp_valid_o clears only on a handshake with no new accept in the same cycle.
- Lookup, combinational on the request side:
  - word_addr = {2'b00, addr[31:2]}.
  - Region i matches if word_addr_low <= word_addr < word_addr_high. A region with low >= high never matches.
  - The lowest matching index wins, and resp_region_o = i.
  - No match: PMA_R_DEFAULT is used and region = PMA_NUM_REGIONS.
  - If PMA_NUM_REGIONS = 0: NO_PMA_R_DEFAULT is used and region = 0.
  - req_debug_region_i overrides everything. It applies the debug attributes (main = 1, bufferable = 0, cacheable = 0, atomic = 0) and region = PMA_NUM_REGIONS + 1.
- err = OR of the following:
  - atomic && !atomic_attr;
  - instr && !main;
  - (misaligned || modified) && !main;
  - pushpop && !main.
- bufferable = attr.bufferable && !instr && !atomic && !load.
- cacheable = attr.cacheable.
- Error tracking is evaluated on accepted requests whose computed err = 1, in the accept cycle. It updates the registers on the next edge.
  - err_clear_i is applied first: err_valid and the counter are zeroed, then same-cycle new errors are applied on top.
  - Capture happens only when err_valid is 0 after the clear step. The lowest erroring channel index is stored in err_ch/err_addr, and err_valid is set to 1.
  - err_cnt increases by the number of erroring channels accepted that cycle, and saturates at 2^ERR_CNT_W-1 with no wrap.
  - err_valid is sticky until err_clear_i.
- Reset mid-operation: all state returns asynchronously to reset values and in-flight responses are dropped.

Test Plan:
- Single region: cfg[0] = {low 0x0, high 0x4000, main = 1, bufferable = 1}. ch1 store at 0x0000_FFFC is accepted in cycle 0, so in cycle 1: resp_valid = 1, err = 0, bufferable = 1, region = 0. The same address as a load gives bufferable = 0.
- Overlapping regions: regions 0 and 1 both cover 0x1000; region 0 has main = 0. ch0 fetch at 0x1000 gives region = 0 and err = 1. Unmapped 0xF000_0000 gives region = PMA_NUM_REGIONS and the default attributes.
- Backpressure: ch0 resp_ready_i = 0 for 3 cycles → req_ready_o = 0 and the response is held stable. Releasing ready with req_valid_i = 1 gives a handshake and a new accept in the same cycle, and resp_valid stays 1.
- Simultaneous errors: ch0 fetch at a main = 0 address 0xA000_0000 and ch1 misaligned access at a main = 0 address 0xB000_0000 in the same cycle → err_ch = 0, err_addr = 0xA000_0000, err_cnt = 2. Asserting err_clear_i together with one new error → err_cnt = 1, with the new record captured.
- Saturation: with ERR_CNT_W = 2, 5 erroring accepts → err_cnt = 3.
- Debug override, and A_EXT = A_NONE with a region where atomic = 1: atomic access gives err = 1. With req_debug_region_i = 1: region = PMA_NUM_REGIONS + 1, cacheable = 0, and the fetch has err = 0. Asserting rst mid-response gives resp_valid = 0 immediately.

Source files
------------

// File: rtl/cv32e40x_pma_checker.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40x_pma_checker (with package cv32e40x_pma_pkg)
// Description : Multi-channel pipelined PMA checker. One shared region table
//               serves NUM_CH independent request channels. Each channel has
//               a single-entry registered response stage with a valid/ready
//               handshake. A saturating error counter and a first-error
//               capture register are kept for debug/trace.
// Ports       : clk, rst                  - clock, async active-high reset
//               req_*_i / req_ready_o     - per-channel request side
//               resp_*_o / resp_ready_i   - per-channel registered response
//               err_valid_o/err_ch_o/err_addr_o/err_cnt_o, err_clear_i
//                                         - first-error record and counter
// Revision    : 1.0 - initial release
// ============================================================================

package cv32e40x_pma_pkg;

  typedef enum logic [1:0] {
    A_NONE   = 2'd0,
    A_ZALRSC = 2'd1,
    A_ATOMIC = 2'd2
  } a_ext_e;

  typedef struct packed {
    logic [31:0] word_addr_low;
    logic [31:0] word_addr_high;
    logic        main;
    logic        bufferable;
    logic        cacheable;
    logic        atomic;
  } pma_cfg_t;

  // Attributes of addresses that fall outside every configured region.
  localparam pma_cfg_t PMA_R_DEFAULT = '{
    word_addr_low : 32'h0, word_addr_high : 32'h0,
    main : 1'b0, bufferable : 1'b0, cacheable : 1'b0, atomic : 1'b0};

  // Attributes used when no PMA regions are configured at all.
  localparam pma_cfg_t NO_PMA_R_DEFAULT = '{
    word_addr_low : 32'h0, word_addr_high : 32'h0,
    main : 1'b1, bufferable : 1'b0, cacheable : 1'b0, atomic : 1'b1};

endpackage

module cv32e40x_pma_checker
  import cv32e40x_pma_pkg::*;
#(
  parameter a_ext_e                          A_EXT           = A_NONE,
  parameter int                              PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t [PMA_NUM_REGIONS-1:0]  PMA_CFG         = '{default: PMA_R_DEFAULT},
  parameter int                              NUM_CH          = 2,
  parameter int                              ERR_CNT_W       = 8,
  localparam int                             REG_W           = $clog2(PMA_NUM_REGIONS + 2),
  localparam int                             CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [NUM_CH-1:0]            req_valid_i,
  output logic [NUM_CH-1:0]            req_ready_o,
  input  logic [NUM_CH-1:0][31:0]      req_addr_i,
  input  logic [NUM_CH-1:0]            req_debug_region_i,
  input  logic [NUM_CH-1:0]            req_pushpop_i,
  input  logic [NUM_CH-1:0]            req_instr_i,
  input  logic [NUM_CH-1:0]            req_atomic_i,
  input  logic [NUM_CH-1:0]            req_misaligned_i,
  input  logic [NUM_CH-1:0]            req_modified_i,
  input  logic [NUM_CH-1:0]            req_load_i,

  output logic [NUM_CH-1:0]            resp_valid_o,
  input  logic [NUM_CH-1:0]            resp_ready_i,
  output logic [NUM_CH-1:0]            resp_err_o,
  output logic [NUM_CH-1:0]            resp_bufferable_o,
  output logic [NUM_CH-1:0]            resp_cacheable_o,
  output logic [NUM_CH-1:0][REG_W-1:0] resp_region_o,

  output logic                         err_valid_o,
  output logic [CH_W-1:0]              err_ch_o,
  output logic [31:0]                  err_addr_o,
  output logic [ERR_CNT_W-1:0]         err_cnt_o,
  input  logic                         err_clear_i
);

  // Extra headroom so that adding up to NUM_CH (<= 4) hits never wraps
  // before the saturation compare.
  localparam int                 SUM_W   = ERR_CNT_W + 3;
  localparam logic [SUM_W-1:0]   CNT_MAX = {3'b000, {ERR_CNT_W{1'b1}}};

  logic [NUM_CH-1:0]            accept;
  logic [NUM_CH-1:0]            lookup_err;
  logic [NUM_CH-1:0]            lookup_bufferable;
  logic [NUM_CH-1:0]            lookup_cacheable;
  logic [NUM_CH-1:0][REG_W-1:0] lookup_region;
  logic [NUM_CH-1:0]            err_hit;

  // A slot is free when empty or when its current response leaves this cycle.
  assign req_ready_o = ~resp_valid_o | resp_ready_i;
  assign accept      = req_valid_i & req_ready_o;
  assign err_hit     = accept & lookup_err;

  // --------------------------------------------------------------------------
  // Per-channel combinational region lookup
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [31:0]      word_addr;
    logic             attr_main;
    logic             attr_bufferable;
    logic             attr_cacheable;
    logic             attr_atomic;
    logic [REG_W-1:0] region;

    always_comb begin
      word_addr = {2'b00, req_addr_i[c][31:2]};

      if (PMA_NUM_REGIONS == 0) begin
        attr_main       = NO_PMA_R_DEFAULT.main;
        attr_bufferable = NO_PMA_R_DEFAULT.bufferable;
        attr_cacheable  = NO_PMA_R_DEFAULT.cacheable;
        attr_atomic     = NO_PMA_R_DEFAULT.atomic;
        region          = '0;
      end else begin
        attr_main       = PMA_R_DEFAULT.main;
        attr_bufferable = PMA_R_DEFAULT.bufferable;
        attr_cacheable  = PMA_R_DEFAULT.cacheable;
        attr_atomic     = PMA_R_DEFAULT.atomic;
        region          = REG_W'(PMA_NUM_REGIONS);
      end

      // Walk from the highest index down so the lowest matching index is the
      // one left standing. A region with low >= high can never satisfy both
      // compares and therefore never matches.
      for (int i = PMA_NUM_REGIONS - 1; i >= 0; i--) begin
        if ((word_addr >= PMA_CFG[i].word_addr_low) &&
            (word_addr <  PMA_CFG[i].word_addr_high)) begin
          attr_main       = PMA_CFG[i].main;
          attr_bufferable = PMA_CFG[i].bufferable;
          attr_cacheable  = PMA_CFG[i].cacheable;
          attr_atomic     = PMA_CFG[i].atomic;
          region          = REG_W'(i);
        end
      end

      // Debug-module region overrides any table match.
      if (req_debug_region_i[c]) begin
        attr_main       = 1'b1;
        attr_bufferable = 1'b0;
        attr_cacheable  = 1'b0;
        attr_atomic     = 1'b0;
        region          = REG_W'(PMA_NUM_REGIONS + 1);
      end

      // Without the A extension no region may claim atomic support.
      if (A_EXT == A_NONE) begin
        attr_atomic = 1'b0;
      end
    end

    assign lookup_err[c] =
        (req_atomic_i[c] && !attr_atomic) ||
        ((req_instr_i[c] || req_misaligned_i[c] || req_modified_i[c] ||
          req_pushpop_i[c]) && !attr_main);

    assign lookup_bufferable[c] = attr_bufferable && !req_instr_i[c] &&
                                  !req_atomic_i[c] && !req_load_i[c];
    assign lookup_cacheable[c]  = attr_cacheable;
    assign lookup_region[c]     = region;
  end

  // --------------------------------------------------------------------------
  // Response stage: one registered entry per channel
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_o      <= '0;
      resp_err_o        <= '0;
      resp_bufferable_o <= '0;
      resp_cacheable_o  <= '0;
      resp_region_o     <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (accept[c]) begin
          resp_valid_o[c]      <= 1'b1;
          resp_err_o[c]        <= lookup_err[c];
          resp_bufferable_o[c] <= lookup_bufferable[c];
          resp_cacheable_o[c]  <= lookup_cacheable[c];
          resp_region_o[c]     <= lookup_region[c];
        end else if (resp_ready_i[c]) begin
          resp_valid_o[c]      <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Error tracking: clear first, then apply this cycle's errors on top
  // --------------------------------------------------------------------------
  logic                 valid_base;
  logic [SUM_W-1:0]     cnt_sum;
  logic [CH_W-1:0]      first_ch;
  logic [31:0]          first_addr;
  logic                 capture;
  logic                 err_valid_nxt;
  logic [ERR_CNT_W-1:0] err_cnt_nxt;

  always_comb begin
    valid_base = err_clear_i ? 1'b0 : err_valid_o;
    cnt_sum    = err_clear_i ? '0 : SUM_W'(err_cnt_o);
    first_ch   = '0;
    first_addr = '0;
    // Descending walk leaves the lowest erroring channel selected.
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (err_hit[c]) begin
        first_ch   = CH_W'(c);
        first_addr = req_addr_i[c];
      end
      cnt_sum = cnt_sum + SUM_W'(err_hit[c]);
    end
    capture       = !valid_base && (|err_hit);
    err_valid_nxt = valid_base || (|err_hit);
    err_cnt_nxt   = (cnt_sum > CNT_MAX) ? {ERR_CNT_W{1'b1}} : cnt_sum[ERR_CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid_o <= 1'b0;
      err_ch_o    <= '0;
      err_addr_o  <= '0;
      err_cnt_o   <= '0;
    end else begin
      err_valid_o <= err_valid_nxt;
      err_cnt_o   <= err_cnt_nxt;
      if (capture) begin
        err_ch_o   <= first_ch;
        err_addr_o <= first_addr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40x_pma_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40x_pma_checker
// Description : Self-checking bench for cv32e40x_pma_checker. Directed steps
//               push expected responses into per-channel queues; a negedge
//               monitor pops and compares them whenever a response leaves.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40x_pma_checker;
  import cv32e40x_pma_pkg::*;

  localparam int NCH   = 2;
  localparam int NREG  = 5;
  localparam int RW    = 3;
  localparam int CNT_W = 2;

  // Region table (word addresses)
  localparam pma_cfg_t R0 = '{word_addr_low:32'h0000_0400, word_addr_high:32'h0000_0500,
                              main:1'b0, bufferable:1'b0, cacheable:1'b0, atomic:1'b0};
  localparam pma_cfg_t R1 = '{word_addr_low:32'h0000_0000, word_addr_high:32'h0000_4000,
                              main:1'b1, bufferable:1'b1, cacheable:1'b1, atomic:1'b1};
  localparam pma_cfg_t R2 = '{word_addr_low:32'h2800_0000, word_addr_high:32'h2C00_0000,
                              main:1'b0, bufferable:1'b0, cacheable:1'b1, atomic:1'b0};
  localparam pma_cfg_t R3 = '{word_addr_low:32'h2C00_0000, word_addr_high:32'h3000_0000,
                              main:1'b0, bufferable:1'b1, cacheable:1'b0, atomic:1'b0};
  localparam pma_cfg_t R4 = '{word_addr_low:32'h3C00_0000, word_addr_high:32'h3C00_0000,
                              main:1'b1, bufferable:1'b1, cacheable:1'b1, atomic:1'b1};
  localparam pma_cfg_t [NREG-1:0] CFG = {R4, R3, R2, R1, R0};

  // Request flag bits
  localparam logic [6:0] F_INSTR  = 7'h01;
  localparam logic [6:0] F_LOAD   = 7'h02;
  localparam logic [6:0] F_ATOMIC = 7'h04;
  localparam logic [6:0] F_MIS    = 7'h08;
  localparam logic [6:0] F_MOD    = 7'h10;
  localparam logic [6:0] F_PP     = 7'h20;
  localparam logic [6:0] F_DBG    = 7'h40;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NCH-1:0]            req_valid_i = '0;
  logic [NCH-1:0]            req_ready_o;
  logic [NCH-1:0][31:0]      req_addr_i = '0;
  logic [NCH-1:0]            req_debug_region_i = '0;
  logic [NCH-1:0]            req_pushpop_i = '0;
  logic [NCH-1:0]            req_instr_i = '0;
  logic [NCH-1:0]            req_atomic_i = '0;
  logic [NCH-1:0]            req_misaligned_i = '0;
  logic [NCH-1:0]            req_modified_i = '0;
  logic [NCH-1:0]            req_load_i = '0;
  logic [NCH-1:0]            resp_valid_o;
  logic [NCH-1:0]            resp_ready_i = '1;
  logic [NCH-1:0]            resp_err_o;
  logic [NCH-1:0]            resp_bufferable_o;
  logic [NCH-1:0]            resp_cacheable_o;
  logic [NCH-1:0][RW-1:0]    resp_region_o;
  logic                      err_valid_o;
  logic                      err_ch_o;
  logic [31:0]               err_addr_o;
  logic [CNT_W-1:0]          err_cnt_o;
  logic                      err_clear_i = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          err;
    logic          bufferable;
    logic          cacheable;
    logic [RW-1:0] region;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  cv32e40x_pma_checker #(
    .A_EXT           (A_NONE),
    .PMA_NUM_REGIONS (NREG),
    .PMA_CFG         (CFG),
    .NUM_CH          (NCH),
    .ERR_CNT_W       (CNT_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_addr_i         (req_addr_i),
    .req_debug_region_i (req_debug_region_i),
    .req_pushpop_i      (req_pushpop_i),
    .req_instr_i        (req_instr_i),
    .req_atomic_i       (req_atomic_i),
    .req_misaligned_i   (req_misaligned_i),
    .req_modified_i     (req_modified_i),
    .req_load_i         (req_load_i),
    .resp_valid_o       (resp_valid_o),
    .resp_ready_i       (resp_ready_i),
    .resp_err_o         (resp_err_o),
    .resp_bufferable_o  (resp_bufferable_o),
    .resp_cacheable_o   (resp_cacheable_o),
    .resp_region_o      (resp_region_o),
    .err_valid_o        (err_valid_o),
    .err_ch_o           (err_ch_o),
    .err_addr_o         (err_addr_o),
    .err_cnt_o          (err_cnt_o),
    .err_clear_i        (err_clear_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid_i        = '0;
    req_debug_region_i = '0;
    req_pushpop_i      = '0;
    req_instr_i        = '0;
    req_atomic_i       = '0;
    req_misaligned_i   = '0;
    req_modified_i     = '0;
    req_load_i         = '0;
  endtask

  // Drive one request on a channel and record the response it must produce.
  task automatic send(input int ch, input logic [31:0] addr, input logic [6:0] f,
                      input logic e_err, input logic e_buf, input logic e_cache,
                      input logic [RW-1:0] e_reg);
    exp_t e;
    req_valid_i[ch]        = 1'b1;
    req_addr_i[ch]         = addr;
    req_instr_i[ch]        = f[0];
    req_load_i[ch]         = f[1];
    req_atomic_i[ch]       = f[2];
    req_misaligned_i[ch]   = f[3];
    req_modified_i[ch]     = f[4];
    req_pushpop_i[ch]      = f[5];
    req_debug_region_i[ch] = f[6];
    e = '{err:e_err, bufferable:e_buf, cacheable:e_cache, region:e_reg};
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  // Scoreboard: a response leaving on the next edge is compared here.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (!rst && resp_valid_o[c] && resp_ready_i[c]) begin
        exp_t e;
        logic have;
        have = 1'b0;
        e    = '0;
        if (c == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (c == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        chk($sformatf("ch%0d_resp_expected", c), {31'd0, have}, 32'd1);
        chk($sformatf("ch%0d_err", c),        {31'd0, resp_err_o[c]},        {31'd0, e.err});
        chk($sformatf("ch%0d_bufferable", c), {31'd0, resp_bufferable_o[c]}, {31'd0, e.bufferable});
        chk($sformatf("ch%0d_cacheable", c),  {31'd0, resp_cacheable_o[c]},  {31'd0, e.cacheable});
        chk($sformatf("ch%0d_region", c),     {29'd0, resp_region_o[c]},     {29'd0, e.region});
      end
    end
  end

  initial begin
    // ---- reset state
    tick(); tick();
    chk("rst_resp_valid", {30'd0, resp_valid_o}, 32'd0);
    chk("rst_resp_region", {26'd0, resp_region_o}, 32'd0);
    chk("rst_err_valid", {31'd0, err_valid_o}, 32'd0);
    chk("rst_err_ch", {31'd0, err_ch_o}, 32'd0);
    chk("rst_err_addr", err_addr_o, 32'd0);
    chk("rst_err_cnt", {30'd0, err_cnt_o}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready_o}, 32'd3);
    rst = 1'b0;
    tick();

    // ---- single-region hit, back-to-back store then load on ch1
    send(1, 32'h0000_FFFC, 7'h00, 1'b0, 1'b1, 1'b1, 3'd1);
    tick();
    chk("latency_valid", {31'd0, resp_valid_o[1]}, 32'd1);
    chk("b2b_ready", {31'd0, req_ready_o[1]}, 32'd1);
    idle();
    send(1, 32'h0000_FFFC, F_LOAD, 1'b0, 1'b0, 1'b1, 3'd1);
    tick();
    idle();
    tick();
    chk("drain_valid", {30'd0, resp_valid_o}, 32'd0);

    // ---- overlap (lowest wins) and unmapped through an empty region
    send(0, 32'h0000_1000, F_INSTR, 1'b1, 1'b0, 1'b0, 3'd0);
    send(1, 32'hF000_0000, F_LOAD,  1'b0, 1'b0, 1'b0, 3'd5);
    tick();
    idle();
    chk("ovl_err_valid", {31'd0, err_valid_o}, 32'd1);
    chk("ovl_err_addr", err_addr_o, 32'h0000_1000);
    chk("ovl_err_cnt", {30'd0, err_cnt_o}, 32'd1);
    // upper region boundaries
    send(0, 32'h0001_0000, F_LOAD, 1'b0, 1'b0, 1'b0, 3'd5);
    send(1, 32'h0000_1400, 7'h00,  1'b0, 1'b1, 1'b1, 3'd1);
    tick();
    idle();
    chk("bnd_err_cnt", {30'd0, err_cnt_o}, 32'd1);

    // ---- clear alone
    err_clear_i = 1'b1;
    tick();
    err_clear_i = 1'b0;
    chk("clr_err_valid", {31'd0, err_valid_o}, 32'd0);
    chk("clr_err_cnt", {30'd0, err_cnt_o}, 32'd0);

    // ---- simultaneous errors on both channels
    send(0, 32'hA000_0000, F_INSTR,          1'b1, 1'b0, 1'b1, 3'd2);
    send(1, 32'hB000_0000, F_MIS | F_LOAD,   1'b1, 1'b0, 1'b0, 3'd3);
    tick();
    idle();
    chk("sim_err_valid", {31'd0, err_valid_o}, 32'd1);
    chk("sim_err_ch", {31'd0, err_ch_o}, 32'd0);
    chk("sim_err_addr", err_addr_o, 32'hA000_0000);
    chk("sim_err_cnt", {30'd0, err_cnt_o}, 32'd2);

    // ---- clear together with one new error
    err_clear_i = 1'b1;
    send(1, 32'hB000_0004, F_PP, 1'b1, 1'b1, 1'b0, 3'd3);
    tick();
    idle();
    err_clear_i = 1'b0;
    chk("clrnew_err_valid", {31'd0, err_valid_o}, 32'd1);
    chk("clrnew_err_ch", {31'd0, err_ch_o}, 32'd1);
    chk("clrnew_err_addr", err_addr_o, 32'hB000_0004);
    chk("clrnew_err_cnt", {30'd0, err_cnt_o}, 32'd1);

    // ---- saturation: 5 erroring accepts with a 2-bit counter
    err_clear_i = 1'b1;
    tick();
    err_clear_i = 1'b0;
    send(0, 32'h0000_1000, F_INSTR, 1'b1, 1'b0, 1'b0, 3'd0);
    send(1, 32'h0000_1000, F_MOD,   1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    chk("sat_cnt_2", {30'd0, err_cnt_o}, 32'd2);
    idle();
    send(0, 32'h0000_1000, F_INSTR, 1'b1, 1'b0, 1'b0, 3'd0);
    send(1, 32'h0000_1000, F_MOD,   1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    chk("sat_cnt_4to3", {30'd0, err_cnt_o}, 32'd3);
    idle();
    send(0, 32'h0000_1000, F_INSTR, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    idle();
    chk("sat_cnt_5", {30'd0, err_cnt_o}, 32'd3);
    chk("sat_err_ch", {31'd0, err_ch_o}, 32'd0);
    chk("sat_err_addr", err_addr_o, 32'h0000_1000);

    // ---- atomic with A_NONE on an atomic-capable region
    send(1, 32'h0000_0100, F_ATOMIC, 1'b1, 1'b0, 1'b1, 3'd1);
    tick();
    idle();

    // ---- debug override
    send(0, 32'h0000_1000, F_INSTR | F_DBG,  1'b0, 1'b0, 1'b0, 3'd6);
    send(1, 32'h0000_0100, F_ATOMIC | F_DBG, 1'b1, 1'b0, 1'b0, 3'd6);
    tick();
    idle();
    tick();

    // ---- backpressure on ch0
    resp_ready_i[0] = 1'b0;
    send(0, 32'h0000_0200, F_LOAD, 1'b0, 1'b0, 1'b1, 3'd1);
    tick();
    idle();
    send(0, 32'h0000_0300, 7'h00, 1'b0, 1'b1, 1'b1, 3'd1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_req_ready", {31'd0, req_ready_o[0]}, 32'd0);
      chk("bp_valid_held", {31'd0, resp_valid_o[0]}, 32'd1);
      chk("bp_buf_held", {31'd0, resp_bufferable_o[0]}, 32'd0);
      chk("bp_region_held", {29'd0, resp_region_o[0]}, 32'd1);
      tick();
    end
    resp_ready_i[0] = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, req_ready_o[0]}, 32'd1);
    tick();
    idle();
    chk("bp_refill_valid", {31'd0, resp_valid_o[0]}, 32'd1);
    chk("bp_refill_buf", {31'd0, resp_bufferable_o[0]}, 32'd1);
    tick();
    chk("bp_empty_valid", {31'd0, resp_valid_o[0]}, 32'd0);

    // ---- asynchronous reset with a response in flight
    resp_ready_i[1] = 1'b0;
    send(1, 32'h0000_0200, F_LOAD, 1'b0, 1'b0, 1'b1, 3'd1);
    tick();
    idle();
    chk("pre_rst_valid", {31'd0, resp_valid_o[1]}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {30'd0, resp_valid_o}, 32'd0);
    chk("async_rst_cnt", {30'd0, err_cnt_o}, 32'd0);
    chk("async_rst_err_valid", {31'd0, err_valid_o}, 32'd0);
    q1.delete();
    resp_ready_i[1] = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
